// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier datapath and its control FSM.
package mult_pkg;

  // Default half width of the product register.
  localparam int MULT_W_DEFAULT = 8;

  // Width of the step counter at the default half width.
  // The counter must be able to hold the value W itself.
  localparam int STEP_W = $clog2(MULT_W_DEFAULT + 1);

  // Step count type, shared with the control FSM.
  typedef logic [STEP_W-1:0] step_t;

endpackage

// File: rtl/product_shift_reg_step_counter.sv
// Saturating 0..W step counter with a registered done flag.
module step_counter #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          restart,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          done
);

  // Count accepted steps. Once done is set, further enables are ignored,
  // so the count parks at W. done is set on the edge that moves count to W.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count <= '0;
      done  <= 1'b0;
    end else if (restart) begin
      count <= '0;
      done  <= 1'b0;
    end else if (enable && !done) begin
      count <= count + CW'(1);
      done  <= (count == CW'(W - 1));
    end
  end

endmodule

// File: rtl/product_shift_reg.sv
// Double-wide product register for the shift-add multiplier: half loads,
// right shift with carry-in, combined add-and-shift, and step counting.
module product_shift_reg
  import mult_pkg::*;
#(
  parameter int W  = MULT_W_DEFAULT,
  parameter int CW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [W-1:0]    inh,
  input  logic [W-1:0]    inl,
  input  logic            loadh,
  input  logic            loadl,
  input  logic            shift,
  input  logic            cin,
  output logic [2*W-1:0]  out,
  output logic            lsb,
  output logic [CW-1:0]   count,
  output logic            done
);

  logic [2*W-1:0] out_next;
  logic           accept;
  logic           step_en;

  // A shift is only accepted while the step budget is not exhausted.
  assign accept  = shift && !done;
  // loadl wins over everything, so a shift alongside it is not a step.
  assign step_en = accept && !loadl;
  assign lsb     = out[0];

  // Next-value mux for the product register, in priority order.
  always_comb begin
    out_next = out;
    if (loadl) begin
      out_next[W-1:0] = inl;
      if (loadh) begin
        out_next[2*W-1:W] = inh;
      end
    end else if (loadh && accept) begin
      // Adder sum lands in the high half while the register shifts right.
      out_next = {cin, inh, out[W-1:1]};
    end else if (loadh) begin
      out_next[2*W-1:W] = inh;
    end else if (accept) begin
      out_next = {cin, out[2*W-1:1]};
    end
  end

  // Product register state.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end

  step_counter #(
    .W  (W),
    .CW (CW)
  ) u_step_counter (
    .clk     (clk),
    .clear   (clear),
    .restart (loadl),
    .enable  (step_en),
    .count   (count),
    .done    (done)
  );

endmodule

// File: tb/tb_product_shift_reg.sv
// Scoreboard bench for product_shift_reg at W = 8.
module tb_product_shift_reg;
  import mult_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          clear;
  logic [W-1:0]  inh;
  logic [W-1:0]  inl;
  logic          loadh;
  logic          loadl;
  logic          shift;
  logic          cin;
  logic [2*W-1:0] out;
  logic          lsb;
  logic [CW-1:0] count;
  logic          done;

  product_shift_reg #(.W(W)) dut (
    .clk   (clk),
    .clear (clear),
    .inh   (inh),
    .inl   (inl),
    .loadh (loadh),
    .loadl (loadl),
    .shift (shift),
    .cin   (cin),
    .out   (out),
    .lsb   (lsb),
    .count (count),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] out;
    step_t       count;
    logic        done;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_out;
  step_t       m_count;
  logic        m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural reference for one clock edge, written from the operation table.
  task automatic model_edge(input logic ll, input logic lh, input logic sh,
                            input logic [7:0] h, input logic [7:0] l, input logic c);
    if (ll) begin
      m_out[7:0] = l;
      if (lh) m_out[15:8] = h;
      m_count = '0;
      m_done  = 1'b0;
    end else if (lh && sh && !m_done) begin
      m_out   = {c, h, m_out[7:1]};
      m_count = m_count + 4'd1;
      m_done  = (m_count == 4'd8);
    end else if (lh) begin
      m_out[15:8] = h;
    end else if (sh && !m_done) begin
      m_out   = {c, m_out[15:1]};
      m_count = m_count + 4'd1;
      m_done  = (m_count == 4'd8);
    end
  endtask

  task automatic step(input logic ll, input logic lh, input logic sh,
                      input logic [7:0] h, input logic [7:0] l, input logic c);
    exp_t e;
    @(negedge clk);
    loadl = ll; loadh = lh; shift = sh; inh = h; inl = l; cin = c;
    model_edge(ll, lh, sh, h, l, c);
    e.out = m_out; e.count = m_count; e.done = m_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("out",   32'(out),   32'(e.out));
      check("lsb",   32'(lsb),   32'(e.out[0]));
      check("count", 32'(count), 32'(e.count));
      check("done",  32'(done),  32'(e.done));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    loadl = 1'b0; loadh = 1'b0; shift = 1'b0; cin = 1'b0;
  endtask

  logic [8:0] sum;
  localparam logic [7:0] MCAND = 8'h0D;

  initial begin
    clear = 1'b1;
    inh = '0; inl = '0; loadh = 1'b0; loadl = 1'b0; shift = 1'b0; cin = 1'b0;
    m_out = '0; m_count = '0; m_done = 1'b0;

    @(negedge clk);
    check("rst_out",   32'(out),   32'h0);
    check("rst_lsb",   32'(lsb),   32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_done",  32'(done),  32'h0);
    clear = 1'b0;

    // Asynchronous clear mid-cycle on a loaded register.
    step(1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
    check("pre_clear", 32'(out), 32'h1234);
    #2;
    clear = 1'b1;
    #1;
    check("clr_out",   32'(out),   32'h0);
    check("clr_count", 32'(count), 32'h0);
    check("clr_done",  32'(done),  32'h0);
    #1;
    clear = 1'b0;
    m_out = '0; m_count = '0; m_done = 1'b0;

    // Plain shift with carry-in.
    step(1'b1, 1'b1, 1'b0, 8'h80, 8'h01, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    check("shift_out", 32'(out), 32'hC000);

    // Add-and-shift.
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0);
    check("addsh_out", 32'(out), 32'h52FF);

    // Full multiply 0x0D * 0x0B with the external adder modelled here.
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h0B, 1'b0);
    for (int i = 0; i < W; i++) begin
      sum = {1'b0, m_out[15:8]} + (m_out[0] ? {1'b0, MCAND} : 9'd0);
      step(1'b0, 1'b1, 1'b1, sum[7:0], 8'h00, sum[8]);
    end
    check("mul_out",  32'(out),  32'(16'(MCAND) * 16'h000B));
    check("mul_const", 32'(out), 32'h008F);
    check("mul_done", 32'(done), 32'h1);

    // Saturation: further shifts are ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    check("sat_out",   32'(out),   32'h008F);
    check("sat_count", 32'(count), 32'h8);

    // loadl beats shift and restarts the count.
    step(1'b1, 1'b0, 1'b1, 8'hFF, 8'h5A, 1'b1);
    check("prio_out",   32'(out),   32'h005A);
    check("prio_count", 32'(count), 32'h0);
    check("prio_done",  32'(done),  32'h0);

    // After done, loadh with shift behaves as loadh alone.
    for (int i = 0; i < W; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, i[0]);
    step(1'b0, 1'b1, 1'b1, 8'h3C, 8'h00, 1'b1);
    check("done_loadh_hi", 32'(out[15:8]), 32'h3C);
    check("done_loadh_cnt", 32'(count), 32'h8);

    // Random mixed stimulus against the reference.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 1'($urandom));
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
